// File: rtl/pcm_pkg.sv
// Shared constants for the PCM capture path: FSM encodings, frame sizes and
// FIFO sizing defaults.
package pcm_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4096;
  localparam int ALMOST_FULL_MARGIN = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_L_LO = 3'd1;
  localparam logic [2:0] ST_WR_L_HI = 3'd2;
  localparam logic [2:0] ST_WR_R_LO = 3'd3;
  localparam logic [2:0] ST_WR_R_HI = 3'd4;

  localparam int FRAME_MONO8    = 1;
  localparam int FRAME_MONO16   = 2;
  localparam int FRAME_STEREO8  = 2;
  localparam int FRAME_STEREO16 = 4;

  function automatic int frame_bytes(input logic stereo, input logic b16);
    case ({stereo, b16})
      2'b00:   return FRAME_MONO8;
      2'b01:   return FRAME_MONO16;
      2'b10:   return FRAME_STEREO8;
      default: return FRAME_STEREO16;
    endcase
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy output.
module capture_fifo import pcm_pkg::*; #(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Handshake: wr_en pushes only when not full, rd_en pops only when not
  // empty; both may happen in one cycle. flush overrides both.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign empty       = (level == '0);
  assign full        = (level == LW'(DEPTH));
  assign almost_full = ((LW'(DEPTH) - level) < LW'(ALMOST_FULL_MARGIN));
  assign rd_data     = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/pcm_capture.sv
// Audio capture front end: rate-divided sampling of L/R inputs, packed into
// little-endian byte frames and pushed whole into a capture FIFO.
module pcm_capture import pcm_pkg::*; #(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        next_sample,
  input  logic [7:0]                  sample_rate,
  input  logic                        mode_stereo,
  input  logic                        mode_16bit,
  input  logic                        capture_enable,
  input  logic [15:0]                 left_in,
  input  logic [15:0]                 right_in,
  input  logic                        fifo_reset,
  input  logic                        fifo_read,
  output logic [7:0]                  fifo_rddata,
  output logic                        fifo_empty,
  output logic                        fifo_almost_full,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic [2:0]                  dbg_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    sr_accum;
  logic          prev_bit7;
  logic          strobe_d;
  logic          new_sample;
  logic [2:0]    state, state_nxt;
  logic          stereo_q, b16_q;
  logic [15:0]   l_q, r_q;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [LW-1:0] free_space;
  logic [LW-1:0] need;
  logic          space_ok;
  logic          accept;

  // A new sample is due whenever the accumulator's top bit toggles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_accum  <= '0;
      prev_bit7 <= 1'b0;
      strobe_d  <= 1'b0;
    end else begin
      strobe_d <= next_sample;
      if (next_sample) begin
        sr_accum  <= sr_accum + sample_rate;
        prev_bit7 <= sr_accum[7];
      end
    end
  end

  assign new_sample = strobe_d & (sr_accum[7] ^ prev_bit7);

  assign free_space = LW'(FIFO_DEPTH) - fifo_level;
  assign need       = LW'(frame_bytes(mode_stereo, mode_16bit));
  assign space_ok   = (free_space >= need);
  assign accept     = new_sample & (state == ST_IDLE) & capture_enable & space_ok;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = mode_16bit ? ST_WR_L_LO : ST_WR_L_HI;
      end
      ST_WR_L_LO: begin
        wr_en     = 1'b1;
        wr_data   = l_q[7:0];
        state_nxt = ST_WR_L_HI;
      end
      ST_WR_L_HI: begin
        wr_en     = 1'b1;
        wr_data   = l_q[15:8];
        state_nxt = !stereo_q ? ST_IDLE : (b16_q ? ST_WR_R_LO : ST_WR_R_HI);
      end
      ST_WR_R_LO: begin
        wr_en     = 1'b1;
        wr_data   = r_q[7:0];
        state_nxt = ST_WR_R_HI;
      end
      ST_WR_R_HI: begin
        wr_en     = 1'b1;
        wr_data   = r_q[15:8];
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      stereo_q <= 1'b0;
      b16_q    <= 1'b0;
      l_q      <= '0;
      r_q      <= '0;
      overrun  <= 1'b0;
    end else if (fifo_reset) begin
      state   <= ST_IDLE;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        stereo_q <= mode_stereo;
        b16_q    <= mode_16bit;
        l_q      <= left_in;
        r_q      <= right_in;
      end
      // Frames are all-or-nothing: a busy FSM or too little room drops it.
      if (new_sample && state != ST_IDLE) overrun <= 1'b1;
      else if (new_sample && capture_enable && !space_ok) overrun <= 1'b1;
    end
  end

  assign dbg_state = state;

  capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (fifo_reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (fifo_read),
    .rd_data     (fifo_rddata),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full),
    .full        (fifo_full),
    .level       (fifo_level)
  );

endmodule

// File: tb/tb_pcm_capture.sv
// Bench for pcm_capture: directed scenarios plus randomized frames checked
// against a byte-queue model of the capture FIFO.
module tb_pcm_capture;
  import pcm_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          next_sample = 1'b0;
  logic [7:0]    sample_rate = 8'd0;
  logic          mode_stereo = 1'b0;
  logic          mode_16bit = 1'b0;
  logic          capture_enable = 1'b0;
  logic [15:0]   left_in = '0;
  logic [15:0]   right_in = '0;
  logic          fifo_reset = 1'b0;
  logic          fifo_read = 1'b0;
  logic [7:0]    fifo_rddata;
  logic          fifo_empty, fifo_almost_full, fifo_full;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int   macc = 0;
  logic movr = 1'b0;

  pcm_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .next_sample      (next_sample),
    .sample_rate      (sample_rate),
    .mode_stereo      (mode_stereo),
    .mode_16bit       (mode_16bit),
    .capture_enable   (capture_enable),
    .left_in          (left_in),
    .right_in         (right_in),
    .fifo_reset       (fifo_reset),
    .fifo_read        (fifo_read),
    .fifo_rddata      (fifo_rddata),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .fifo_level       (fifo_level),
    .overrun          (overrun),
    .dbg_state        (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: accumulator as plain modular arithmetic
  function automatic bit acc_step();
    int nxt;
    bit trig;
    nxt  = (macc + int'(sample_rate)) % 256;
    trig = (nxt / 128) != (macc / 128);
    macc = nxt;
    return trig;
  endfunction

  task automatic model_frame();
    int need;
    need = mode_16bit ? (mode_stereo ? 4 : 2) : (mode_stereo ? 2 : 1);
    if (!capture_enable) return;
    if (DEPTH - exp_q.size() < need) begin
      movr = 1'b1;
      return;
    end
    if (mode_16bit) exp_q.push_back(left_in[7:0]);
    exp_q.push_back(left_in[15:8]);
    if (mode_stereo) begin
      if (mode_16bit) exp_q.push_back(right_in[7:0]);
      exp_q.push_back(right_in[15:8]);
    end
  endtask

  // driver tasks: all enter and leave at a falling edge
  task automatic strobe(input int gap);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    if (acc_step()) model_frame();
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    macc = 0;
    movr = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic do_fifo_reset();
    fifo_reset = 1'b1;
    @(negedge clk);
    fifo_reset = 1'b0;
    exp_q.delete();
    movr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, fifo_level, exp_q.size());
    check({tag, "_ovr"}, overrun, movr);
    check({tag, "_empty"}, fifo_empty, exp_q.size() == 0);
    check({tag, "_full"}, fifo_full, exp_q.size() == DEPTH);
    check({tag, "_afull"}, fifo_almost_full, (DEPTH - exp_q.size()) < 4);
  endtask

  task automatic pop_all(input string tag);
    logic [7:0] b;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check({tag, "_data"}, fifo_rddata, b);
      fifo_read = 1'b1;
      @(negedge clk);
      fifo_read = 1'b0;
    end
    check({tag, "_drained"}, fifo_empty, 1);
  endtask

  task automatic rd_tick();
    @(negedge clk);
    if (!fifo_empty) got_q.push_back(fifo_rddata);
    check("t039_level_le2", fifo_level <= 2, 1);
  endtask

  initial begin
    bit found;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_rddata", fifo_rddata, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_level", fifo_level, 0);
    check("rst_full", fifo_full, 0);
    check("rst_afull", fifo_almost_full, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // stereo 16-bit single frame
    sample_rate = 8'd128; mode_stereo = 1; mode_16bit = 1; capture_enable = 1;
    left_in = 16'h1234; right_in = 16'hABCD;
    strobe(6);
    check("t036_level4", fifo_level, 4);
    check("t036_head", fifo_rddata, 8'h34);
    pop_all("t036");

    // mono 8-bit at half rate: 2 of 4 strobes capture, high byte only
    do_rst();
    sample_rate = 8'd64; mode_stereo = 0; mode_16bit = 0; left_in = 16'h8070;
    repeat (4) strobe(3);
    check("t037_level2", fifo_level, 2);
    pop_all("t037");

    // no room for a whole frame
    do_fifo_reset();
    sample_rate = 8'd128;
    mode_stereo = 1; mode_16bit = 1;
    for (int i = 0; i < 3; i++) begin
      left_in = 16'($urandom); right_in = 16'($urandom);
      strobe(6);
    end
    mode_stereo = 0;
    strobe(6);
    mode_stereo = 1;
    strobe(6);
    check("t038_level14", fifo_level, DEPTH - 2);
    check("t038_ovr1", overrun, 1);
    check_status("t038");
    do_fifo_reset();
    check("t038_flush_level", fifo_level, 0);
    check("t038_flush_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      left_in = 16'($urandom); right_in = 16'($urandom);
      strobe(6);
    end
    check_status("t038_full");
    mode_stereo = 0; mode_16bit = 0;
    strobe(4);
    check_status("t038_fullovr");
    pop_all("t038");

    // strobe while busy, enable dropped mid-frame
    do_fifo_reset();
    mode_stereo = 1; mode_16bit = 1;
    left_in = 16'($urandom); right_in = 16'($urandom);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    if (acc_step()) model_frame();
    @(negedge clk);
    capture_enable = 1'b0;
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    if (acc_step()) movr = 1'b1;
    repeat (5) @(negedge clk);
    check_status("t026");
    pop_all("t026");
    capture_enable = 1'b1;

    // continuous read during stereo 8-bit capture
    do_fifo_reset();
    mode_stereo = 1; mode_16bit = 0;
    got_q.delete();
    fifo_read = 1'b1;
    for (int f = 0; f < 8; f++) begin
      left_in = 16'($urandom); right_in = 16'($urandom);
      next_sample = 1'b1;
      rd_tick();
      next_sample = 1'b0;
      if (acc_step()) model_frame();
      rd_tick();
      rd_tick();
      rd_tick();
    end
    repeat (4) rd_tick();
    fifo_read = 1'b0;
    check("t039_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("t039_byte", got_q[i], exp_q[i]);
    exp_q.delete();
    check("t039_empty", fifo_empty, 1);

    // reset in the middle of a stereo 16-bit frame
    do_rst();
    sample_rate = 8'd128; mode_stereo = 1; mode_16bit = 1;
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == ST_WR_L_HI) found = 1;
    end
    check("t040_reach_lhi", found, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    macc = 0; movr = 0; exp_q.delete();
    @(negedge clk);
    check("t040_level", fifo_level, 0);
    check("t040_empty", fifo_empty, 1);
    check("t040_state", dbg_state, ST_IDLE);
    repeat (6) @(negedge clk);
    check_status("t040_after");

    // stopped rate
    sample_rate = 8'd0;
    for (int i = 0; i < 1000; i++) begin
      next_sample = 1'b1;
      @(negedge clk);
      next_sample = 1'b0;
      if (acc_step()) model_frame();
      @(negedge clk);
    end
    check("t041_level", fifo_level, 0);
    check("t041_ovr", overrun, 0);

    // randomized frames against the queue model
    do_rst();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       sample_rate = 8'd0;
        1:       sample_rate = 8'd64;
        2:       sample_rate = 8'd128;
        default: sample_rate = 8'($urandom_range(0, 255));
      endcase
      mode_stereo    = 1'($urandom_range(0, 1));
      mode_16bit     = 1'($urandom_range(0, 1));
      capture_enable = ($urandom_range(0, 7) != 0);
      left_in        = 16'($urandom);
      right_in       = 16'($urandom);
      strobe(5);
      check_status("rnd");
      if ($urandom_range(0, 5) == 0) pop_all("rnd");
      if ($urandom_range(0, 9) == 0) do_fifo_reset();
    end
    pop_all("rnd_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
